// File: rtl/alu_seq_mult.sv
// Multi-cycle 32x32 shift-and-add multiplier that drives a shared ALU (low product word only).
// Optional macro ALU_SEQ_MULT_EARLY_EXIT_EN: finish as soon as no set multiplier bits remain.
package alu_seq_mult_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module alu_seq_mult
    import alu_seq_mult_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  word_t       opA,
    input  word_t       opB,
    output logic        busy,
    output logic        done,
    output word_t       result,
    output aluop_t      aluop,
    output word_t       portA,
    output word_t       portB,
    input  word_t       outputPort,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    word_t      m_q, m_d;
    word_t      q_q, q_d;
    word_t      p_q, p_d;
    logic [5:0] cnt_q, cnt_d;
    word_t      result_q, result_d;
    word_t      q_next;
    logic       last_bit;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        q_d      = q_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        aluop    = ALU_ADD;
        portA    = '0;
        portB    = '0;
        // Multiplier after this SHIFT step; bit 0 selects whether an ADD follows.
        q_next   = q_q >> 1;
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        last_bit = (cnt_q == 6'(ITER - 1)) || (q_next == '0);
`else
        last_bit = (cnt_q == 6'(ITER - 1));
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = opA;
                    q_d     = opB;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = opB[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                portA   = p_q;
                portB   = m_q;
                p_d     = outputPort;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                aluop   = ALU_SLL;
                portA   = m_q;
                portB   = 32'd1;
                m_d     = outputPort;
                q_d     = q_next;
                cnt_d   = 6'(cnt_q + 6'd1);
                if (last_bit)
                    state_d = S_DONE;
                else
                    state_d = q_next[0] ? S_ADD : S_SHIFT;
            end
            S_DONE: begin
                result_d = p_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            q_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            q_q      <= q_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    // Bypass so the product is already visible during the done pulse.
    assign result    = done ? p_q : result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq_mult.sv
// Directed bench for alu_seq_mult with a behavioural ALU closing the loop on outputPort.
// Latency expectations follow ALU_SEQ_MULT_EARLY_EXIT_EN when it is defined for both files.
module tb_alu_seq_mult;
    import alu_seq_mult_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        start;
    word_t       opA, opB;
    logic        busy, done;
    word_t       result;
    aluop_t      aluop;
    word_t       portA, portB;
    word_t       outputPort;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_mult #(.ITER(32)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result), .aluop(aluop),
        .portA(portA), .portB(portB), .outputPort(outputPort),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference ALU
    always_comb begin
        case (aluop)
            ALU_SLL: outputPort = portA << portB[4:0];
            ALU_ADD: outputPort = portA + portB;
            default: outputPort = 32'hDEAD_BEEF;
        endcase
    end

    // Runs one operation from the start edge; cycle 1 is the cycle after the start edge.
    // restart_at > 0 pulses a second start (9*9) in that cycle.
    task automatic run_op(input word_t a, input word_t b, input int restart_at,
                          output word_t res, output int lat, output int n_add,
                          output int n_shift, output int n_done, output bit busy_ok,
                          output bit tail_ok);
        res = '0; lat = 0; n_add = 0; n_shift = 0; n_done = 0; busy_ok = 1'b1; tail_ok = 1'b0;
        @(negedge CLK);
        opA = a; opB = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (restart_at > 0 && c == restart_at) begin
                opA = 32'd9; opB = 32'd9; start = 1'b1;
            end else if (restart_at > 0 && c == restart_at + 1) begin
                start = 1'b0;
            end
            if (lat != 0 && c == lat + 1) begin
                tail_ok = !busy && !done;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (aluop == ALU_ADD && busy && !done) n_add++;
            if (aluop == ALU_SLL) n_shift++;
            if (done) begin
                n_done++;
                lat = c;
                res = result;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; start = 1'b0; opA = '0; opB = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (aluop !== ALU_ADD) begin n_errors++; $display("FAIL reset_aluop got %0d want %0d", aluop, ALU_ADD); end
        n_checks++; if (portA !== 32'd0) begin n_errors++; $display("FAIL reset_portA got %h want 0", portA); end
        n_checks++; if (portB !== 32'd0) begin n_errors++; $display("FAIL reset_portB got %h want 0", portB); end
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_scenario(input string name, input word_t a, input word_t b,
                                 input int restart_at, input word_t exp_res,
                                 input int exp_lat, input int exp_add, input int exp_shift);
        word_t res; int lat, n_add, n_shift, n_done; bit busy_ok, tail_ok;
        run_op(a, b, restart_at, res, lat, n_add, n_shift, n_done, busy_ok, tail_ok);
        n_checks++; if (res !== exp_res) begin n_errors++; $display("FAIL %s_result got %h want %h", name, res, exp_res); end
        n_checks++; if (lat != exp_lat) begin n_errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        n_checks++; if (n_add != exp_add) begin n_errors++; $display("FAIL %s_adds got %0d want %0d", name, n_add, exp_add); end
        n_checks++; if (n_shift != exp_shift) begin n_errors++; $display("FAIL %s_shifts got %0d want %0d", name, n_shift, exp_shift); end
        n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL %s_done_pulses got %0d want 1", name, n_done); end
        n_checks++; if (!busy_ok) begin n_errors++; $display("FAIL %s_busy_held got 0 want 1", name); end
        n_checks++; if (!tail_ok) begin n_errors++; $display("FAIL %s_idle_after_done got 0 want 1", name); end
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (result !== exp_res) begin n_errors++; $display("FAIL %s_result_held got %h want %h", name, result, exp_res); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_no_requeue got busy=%0b want 0", name, busy); end
    endtask

    task automatic test_basic();
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        test_scenario("mul_7x6", 32'd7, 32'd6, 0, 32'd42, 6, 2, 3);
`else
        test_scenario("mul_7x6", 32'd7, 32'd6, 0, 32'd42, 35, 2, 32);
`endif
    endtask

    task automatic test_all_ones();
        test_scenario("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001, 65, 32, 32);
    endtask

    task automatic test_zero_multiplier();
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        test_scenario("mul_zero", 32'h1234_5678, 32'd0, 0, 32'd0, 2, 0, 1);
`else
        test_scenario("mul_zero", 32'h1234_5678, 32'd0, 0, 32'd0, 33, 0, 32);
`endif
    endtask

    task automatic test_truncation();
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        test_scenario("mul_trunc", 32'h8000_0000, 32'd2, 0, 32'd0, 4, 1, 2);
`else
        test_scenario("mul_trunc", 32'h8000_0000, 32'd2, 0, 32'd0, 34, 1, 32);
`endif
    endtask

    task automatic test_back_to_back();
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        test_scenario("mul_ignore", 32'd3, 32'd5, 3, 32'd15, 6, 2, 3);
`else
        test_scenario("mul_ignore", 32'd3, 32'd5, 3, 32'd15, 35, 2, 32);
`endif
    endtask

    task automatic test_reset_abort();
        int shifts = 0;
        int dones  = 0;
        bit reached = 1'b0;
        @(negedge CLK);
        opA = 32'd3; opB = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done) dones++;
            if (aluop == ALU_SLL) shifts++;
            if (shifts == 10) begin reached = 1'b1; break; end
            @(posedge CLK); #1;
        end
        n_checks++; if (!reached) begin n_errors++; $display("FAIL abort_reach_cnt10 got %0d shifts want 10", shifts); end
        @(posedge CLK); #2;
        nRST = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_checks++; if (result !== 32'd0) begin n_errors++; $display("FAIL abort_result got %h want 0", result); end
        n_checks++; if (aluop !== ALU_ADD || portA !== 32'd0 || portB !== 32'd0) begin
            n_errors++; $display("FAIL abort_alu_ports got op=%0d a=%h b=%h want op=%0d a=0 b=0", aluop, portA, portB, ALU_ADD);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            if (done) dones++;
        end
        @(negedge CLK); nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            if (done) dones++;
        end
        n_checks++; if (dones != 0) begin n_errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
`ifdef ALU_SEQ_MULT_EARLY_EXIT_EN
        test_scenario("mul_after_abort", 32'd4, 32'd4, 0, 32'd16, 5, 1, 3);
`else
        test_scenario("mul_after_abort", 32'd4, 32'd4, 0, 32'd16, 34, 1, 32);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_zero_multiplier();
        test_truncation();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
